// File: rtl/multi_polynomial_finder.sv
// rtl/multi_polynomial_finder.sv - finds which LFSR polynomial and iteration count link two decoded lighthouse words
// Optional feature: define POLY_FINDER_AMBIGUITY_EN to flag simultaneous multi-polynomial matches.
module multi_polynomial_finder #(
  parameter int NUM_POLY    = 2,
  parameter int LFSR_WIDTH  = 17,
  parameter int TS_WIDTH    = 24,
  parameter int ITER_WIDTH  = 17,
  parameter int TICK_SHIFT  = 4,
  parameter int ITER_WINDOW = 2,
  parameter logic [NUM_POLY*LFSR_WIDTH-1:0] POLY_TABLE = {17'h17e04, 17'h1d258}
) (
  input  logic                                          clk_96MHz,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [TS_WIDTH-1:0]                           ts_last_data,
  input  logic [TS_WIDTH-1:0]                           ts_last_data1,
  input  logic [LFSR_WIDTH-1:0]                         decoded_data,
  input  logic [LFSR_WIDTH-1:0]                         decoded_data1,
  output logic                                          ready,
  output logic                                          done,
  output logic                                          found,
  output logic [((NUM_POLY > 1) ? $clog2(NUM_POLY) : 1)-1:0] poly_index,
  output logic [LFSR_WIDTH-1:0]                         polynomial,
  output logic [ITER_WIDTH-1:0]                         iteration_number,
  output logic                                          ambiguous
);

  localparam int IDX_W = (NUM_POLY > 1) ? $clog2(NUM_POLY) : 1;
  // Wide enough for the un-truncated estimate and the saturation test on hi.
  localparam int CW = ((TS_WIDTH > ITER_WIDTH) ? TS_WIDTH : ITER_WIDTH) + 1;
  localparam logic [CW-1:0] ITER_MAX = {{(CW-ITER_WIDTH){1'b0}}, {ITER_WIDTH{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_ESTIMATE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [TS_WIDTH-1:0]   ts0_q, ts1_q;
  logic [LFSR_WIDTH-1:0] seed_q, target_q;
  logic [LFSR_WIDTH-1:0] chan_q [NUM_POLY];
  logic [ITER_WIDTH-1:0] iter_q, hi_q;
  logic [CW-1:0]         lo_q;

  logic [TS_WIDTH-1:0]   delta;
  logic [CW-1:0]         est, hi_raw, hi_d, lo_d;
  logic [NUM_POLY-1:0]   match;
  logic                  in_window, degenerate;
  logic [IDX_W-1:0]      low_idx;
  logic [LFSR_WIDTH-1:0] low_poly;
  logic                  cap_en, load_en, step_en, take_en;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] v,
                                                      input logic [LFSR_WIDTH-1:0] p);
    return {v[LFSR_WIDTH-2:0], ^(v & p)};
  endfunction

  // Unsigned subtraction absorbs a timestamp rollover between the two words.
  always_comb begin
    delta      = ts1_q - ts0_q;
    est        = CW'(delta >> TICK_SHIFT);
    hi_raw     = est + CW'(ITER_WINDOW);
    hi_d       = (hi_raw > ITER_MAX) ? ITER_MAX : hi_raw;
    lo_d       = (est < CW'(ITER_WINDOW)) ? '0 : est - CW'(ITER_WINDOW);
    degenerate = (seed_q == target_q) || (ts0_q == ts1_q);
    in_window  = (CW'(iter_q) >= lo_q) && (iter_q <= hi_q);
  end

  always_comb begin
    match    = '0;
    low_idx  = '0;
    low_poly = '0;
    for (int i = 0; i < NUM_POLY; i++) match[i] = (chan_q[i] == target_q);
    for (int i = NUM_POLY - 1; i >= 0; i--) begin
      if (match[i]) begin
        low_idx  = IDX_W'(i);
        low_poly = POLY_TABLE[i*LFSR_WIDTH +: LFSR_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    cap_en  = 1'b0;
    load_en = 1'b0;
    step_en = 1'b0;
    take_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          cap_en  = 1'b1;
          state_d = S_ESTIMATE;
        end
      end
      S_ESTIMATE: begin
        if (degenerate) begin
          state_d = S_DONE;
        end else begin
          load_en = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (in_window && (|match)) begin
          take_en = 1'b1;
          state_d = S_DONE;
        end else if (iter_q == hi_q) begin
          state_d = S_DONE;
        end else begin
          step_en = 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      state_q          <= S_IDLE;
      ts0_q            <= '0;
      ts1_q            <= '0;
      seed_q           <= '0;
      target_q         <= '0;
      iter_q           <= '0;
      hi_q             <= '0;
      lo_q             <= '0;
      found            <= 1'b0;
      poly_index       <= '0;
      polynomial       <= '0;
      iteration_number <= '0;
      for (int i = 0; i < NUM_POLY; i++) chan_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (cap_en) begin
        ts0_q            <= ts_last_data;
        ts1_q            <= ts_last_data1;
        seed_q           <= decoded_data;
        target_q         <= decoded_data1;
        found            <= 1'b0;
        poly_index       <= '0;
        polynomial       <= '0;
        iteration_number <= '0;
      end
      if (load_en) begin
        iter_q <= '0;
        lo_q   <= lo_d;
        hi_q   <= hi_d[ITER_WIDTH-1:0];
      end else if (step_en) begin
        iter_q <= iter_q + 1'b1;
      end
      for (int i = 0; i < NUM_POLY; i++) begin
        if (load_en)
          chan_q[i] <= seed_q;
        else if (step_en)
          chan_q[i] <= lfsr_step(chan_q[i], POLY_TABLE[i*LFSR_WIDTH +: LFSR_WIDTH]);
      end
      if (take_en) begin
        found            <= 1'b1;
        poly_index       <= low_idx;
        polynomial       <= low_poly;
        iteration_number <= iter_q;
      end
    end
  end

`ifdef POLY_FINDER_AMBIGUITY_EN
  // Clearing the lowest set bit leaves a residue only when two or more channels hit.
  logic multi_hit;
  logic ambiguous_q;
  assign multi_hit = |(match & (match - NUM_POLY'(1)));

  always_ff @(posedge clk_96MHz) begin
    if (reset)
      ambiguous_q <= 1'b0;
    else if (cap_en)
      ambiguous_q <= 1'b0;
    else if (take_en)
      ambiguous_q <= multi_hit;
  end

  assign ambiguous = ambiguous_q;
`else
  assign ambiguous = 1'b0;
`endif

endmodule

// File: tb/tb_multi_polynomial_finder.sv
// tb/tb_multi_polynomial_finder.sv - scoreboard bench for multi_polynomial_finder
module tb_multi_polynomial_finder;

`ifdef POLY_FINDER_AMBIGUITY_EN
  localparam bit EXP_AMB = 1'b1;
`else
  localparam bit EXP_AMB = 1'b0;
`endif

  logic clk_96MHz = 1'b0;
  always #5 clk_96MHz = ~clk_96MHz;

  logic        reset, start_a, start_b;
  logic [23:0] ts0, ts1;
  logic [16:0] d0, d1;

  logic        ready_a, done_a, found_a, amb_a;
  logic [0:0]  idx_a;
  logic [16:0] poly_a, iter_a;
  logic        ready_b, done_b, found_b, amb_b;
  logic [0:0]  idx_b;
  logic [16:0] poly_b, iter_b;

  multi_polynomial_finder dut_a (
    .clk_96MHz(clk_96MHz), .reset(reset), .start(start_a),
    .ts_last_data(ts0), .ts_last_data1(ts1),
    .decoded_data(d0), .decoded_data1(d1),
    .ready(ready_a), .done(done_a), .found(found_a), .poly_index(idx_a),
    .polynomial(poly_a), .iteration_number(iter_a), .ambiguous(amb_a)
  );

  multi_polynomial_finder #(.POLY_TABLE({17'h1d258, 17'h1d258})) dut_b (
    .clk_96MHz(clk_96MHz), .reset(reset), .start(start_b),
    .ts_last_data(ts0), .ts_last_data1(ts1),
    .decoded_data(d0), .decoded_data1(d1),
    .ready(ready_b), .done(done_b), .found(found_b), .poly_index(idx_b),
    .polynomial(poly_b), .iteration_number(iter_b), .ambiguous(amb_b)
  );

  int cur_sel = 0;
  logic        m_ready, m_done, m_found, m_amb;
  logic [0:0]  m_idx;
  logic [16:0] m_poly, m_iter;
  assign m_ready = cur_sel ? ready_b : ready_a;
  assign m_done  = cur_sel ? done_b  : done_a;
  assign m_found = cur_sel ? found_b : found_a;
  assign m_amb   = cur_sel ? amb_b   : amb_a;
  assign m_idx   = cur_sel ? idx_b   : idx_a;
  assign m_poly  = cur_sel ? poly_b  : poly_a;
  assign m_iter  = cur_sel ? iter_b  : iter_a;

  typedef struct {
    string       tag;
    logic        found;
    logic [0:0]  idx;
    logic [16:0] poly;
    logic [16:0] iter;
    logic        amb;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_case(input string tag, input int sel,
                          input logic [16:0] seed, input logic [16:0] tgt,
                          input logic [23:0] t0, input logic [23:0] t1,
                          input logic e_found, input logic [0:0] e_idx,
                          input logic [16:0] e_poly, input logic [16:0] e_iter,
                          input logic e_amb, input int e_lat, input bit poke);
    exp_t e;
    int cyc;
    e.tag = tag; e.found = e_found; e.idx = e_idx; e.poly = e_poly;
    e.iter = e_iter; e.amb = e_amb; e.lat = e_lat;
    sbq.push_back(e);
    cur_sel = sel;
    d0 = seed; d1 = tgt; ts0 = t0; ts1 = t1;
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk_96MHz); #1;
    start_a = 1'b0; start_b = 1'b0;
    cyc = 1;
    check({tag, ".ready_busy"}, 32'(m_ready), 32'd0);
    while (!m_done && cyc < 60) begin
      if (poke && cyc == 2) begin
        start_a = 1'b1;
        d1 = 17'h00012;
      end else begin
        start_a = 1'b0;
      end
      @(posedge clk_96MHz); #1;
      cyc++;
    end
    start_a = 1'b0;
    e = sbq.pop_front();
    if (!m_done) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s.timeout: observed no done expected done", e.tag);
      return;
    end
    check({e.tag, ".latency"}, 32'(cyc), 32'(e.lat));
    check({e.tag, ".ready_done"}, 32'(m_ready), 32'd0);
    check({e.tag, ".found"}, 32'(m_found), 32'(e.found));
    check({e.tag, ".poly_index"}, 32'(m_idx), 32'(e.idx));
    check({e.tag, ".polynomial"}, 32'(m_poly), 32'(e.poly));
    check({e.tag, ".iteration"}, 32'(m_iter), 32'(e.iter));
    check({e.tag, ".ambiguous"}, 32'(m_amb), 32'(e.amb));
    @(posedge clk_96MHz); #1;
    check({e.tag, ".ready_after"}, 32'(m_ready), 32'd1);
    check({e.tag, ".done_pulse"}, 32'(m_done), 32'd0);
    check({e.tag, ".found_hold"}, 32'(m_found), 32'(e.found));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".ready"}, 32'(ready_a), 32'd1);
    check({tag, ".done"}, 32'(done_a), 32'd0);
    check({tag, ".found"}, 32'(found_a), 32'd0);
    check({tag, ".poly_index"}, 32'(idx_a), 32'd0);
    check({tag, ".polynomial"}, 32'(poly_a), 32'd0);
    check({tag, ".iteration"}, 32'(iter_a), 32'd0);
    check({tag, ".ambiguous"}, 32'(amb_a), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    ts0 = '0; ts1 = '0; d0 = '0; d1 = '0;
    repeat (2) @(posedge clk_96MHz);
    #1;
    check_cleared("reset_state");
    check("reset_state.ready_b", 32'(ready_b), 32'd1);
    reset = 1'b0;
    @(posedge clk_96MHz); #1;

    run_case("poly0_iter4", 0, 17'h00001, 17'h00011, 24'h000100, 24'h000140,
             1'b1, 1'b0, 17'h1d258, 17'd4, 1'b0, 7, 1'b0);
    run_case("poly1_iter4", 0, 17'h00001, 17'h00012, 24'h000100, 24'h000140,
             1'b1, 1'b1, 17'h17e04, 17'd4, 1'b0, 7, 1'b0);
    run_case("ts_wrap", 0, 17'h00001, 17'h00011, 24'hFFFFF0, 24'h000030,
             1'b1, 1'b0, 17'h1d258, 17'd4, 1'b0, 7, 1'b0);
    run_case("lo_clamp_miss", 0, 17'h00001, 17'h1FFFF, 24'h000100, 24'h000110,
             1'b0, 1'b0, 17'h0, 17'd0, 1'b0, 6, 1'b0);
    run_case("busy_start_ignored", 0, 17'h00001, 17'h00011, 24'h000100, 24'h000140,
             1'b1, 1'b0, 17'h1d258, 17'd4, 1'b0, 7, 1'b1);
    run_case("data_equal", 0, 17'h0ABCD, 17'h0ABCD, 24'h000100, 24'h000140,
             1'b0, 1'b0, 17'h0, 17'd0, 1'b0, 2, 1'b0);
    run_case("ts_equal", 0, 17'h00001, 17'h00011, 24'h000200, 24'h000200,
             1'b0, 1'b0, 17'h0, 17'd0, 1'b0, 2, 1'b0);
    run_case("hi_edge_hit", 0, 17'h00001, 17'h00046, 24'h000100, 24'h000140,
             1'b1, 1'b0, 17'h1d258, 17'd6, 1'b0, 9, 1'b0);
    run_case("below_lo_miss", 0, 17'h00001, 17'h00002, 24'h000100, 24'h000140,
             1'b0, 1'b0, 17'h0, 17'd0, 1'b0, 9, 1'b0);
    run_case("ambiguity", 1, 17'h00001, 17'h00011, 24'h000100, 24'h000140,
             1'b1, 1'b0, 17'h1d258, 17'd4, EXP_AMB, 7, 1'b0);

    // Held results must be wiped by reset while idle.
    run_case("pre_reset", 0, 17'h00001, 17'h00012, 24'h000100, 24'h000140,
             1'b1, 1'b1, 17'h17e04, 17'd4, 1'b0, 7, 1'b0);
    reset = 1'b1;
    @(posedge clk_96MHz); #1;
    reset = 1'b0;
    check_cleared("idle_reset");

    // Reset in the middle of a search aborts it without a done pulse.
    cur_sel = 0;
    d0 = 17'h00001; d1 = 17'h00011; ts0 = 24'h000100; ts1 = 24'h000140;
    start_a = 1'b1;
    @(posedge clk_96MHz); #1;
    start_a = 1'b0;
    repeat (3) begin @(posedge clk_96MHz); #1; end
    reset = 1'b1;
    @(posedge clk_96MHz); #1;
    reset = 1'b0;
    check_cleared("midrun_reset");
    seen = 0;
    repeat (12) begin
      @(posedge clk_96MHz); #1;
      if (done_a) seen = 1;
    end
    check("midrun_reset.no_done", 32'(seen), 32'd0);

    run_case("after_reset", 0, 17'h00001, 17'h00011, 24'h000100, 24'h000140,
             1'b1, 1'b0, 17'h1d258, 17'd4, 1'b0, 7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
